// File: rtl/vx_csr_ext_router.sv
// Routes one CSR request at a time to one of NUM_EXT external CSR slaves after its warp drains.
// Read data or an error comes back through a small in-order response FIFO.
module vx_csr_ext_router #(
    parameter int NUM_LANES = 4,
    parameter int NUM_EXT   = 2,
    parameter int DATAW     = 32,
    parameter int ADDRW     = 12,
    parameter int WIDW      = 4,
    parameter int TAGW      = 8,
    parameter logic [NUM_EXT*ADDRW-1:0] EXT_BASE = '0,
    parameter logic [NUM_EXT*ADDRW-1:0] EXT_SIZE = '0,
    parameter int TIMEOUT   = 255,
    parameter int OUT_DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic                           req_write,
    input  logic [ADDRW-1:0]               req_addr,
    input  logic [WIDW-1:0]                req_wid,
    input  logic [NUM_LANES-1:0]           req_tmask,
    input  logic [NUM_LANES*DATAW-1:0]     req_data,
    input  logic [TAGW-1:0]                req_tag,
    output logic [WIDW-1:0]                drain_wid,
    input  logic                           drain_empty,
    output logic [NUM_EXT-1:0]             ext_req_valid,
    input  logic [NUM_EXT-1:0]             ext_req_ready,
    output logic                           ext_req_write,
    output logic [ADDRW-1:0]               ext_req_addr,
    output logic [WIDW-1:0]                ext_req_wid,
    output logic [NUM_LANES-1:0]           ext_req_tmask,
    output logic [NUM_LANES*DATAW-1:0]     ext_req_data,
    input  logic [NUM_EXT-1:0]             ext_rsp_valid,
    input  logic [NUM_EXT*NUM_LANES*DATAW-1:0] ext_rsp_data,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [TAGW-1:0]                rsp_tag,
    output logic [WIDW-1:0]                rsp_wid,
    output logic [NUM_LANES-1:0]           rsp_tmask,
    output logic [NUM_LANES*DATAW-1:0]     rsp_data,
    output logic                           rsp_err,
    output logic                           busy
);
    localparam int LDW  = NUM_LANES * DATAW;
    localparam int SELW = (NUM_EXT > 1) ? $clog2(NUM_EXT) : 1;
    localparam int TMRW = $clog2(TIMEOUT + 1);
    localparam int EW   = TAGW + WIDW + NUM_LANES + LDW + 1;
    localparam int PTRW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CNTW = $clog2(OUT_DEPTH + 1);

    typedef enum logic [2:0] {S_IDLE, S_DRAIN, S_ISSUE, S_WAIT, S_PUSH} state_t;

    state_t              state;
    logic                write_q;
    logic [ADDRW-1:0]    addr_q;
    logic [WIDW-1:0]     wid_q;
    logic [NUM_LANES-1:0] tmask_q;
    logic [LDW-1:0]      data_q;
    logic [TAGW-1:0]     tag_q;
    logic [SELW-1:0]     sel_q;
    logic [TMRW-1:0]     timer;
    logic [LDW-1:0]      rdata_q;
    logic                err_q;
    logic [NUM_EXT-1:0]  ext_valid_q;
    logic [WIDW-1:0]     drain_q;

    logic                hit;
    logic [SELW-1:0]     hit_sel;
    logic [ADDRW:0]      lo, hi;
    logic [LDW-1:0]      rsp_slice, rsp_masked;

    logic [EW-1:0]       mem [OUT_DEPTH];
    logic [PTRW-1:0]     wr_ptr, rd_ptr;
    logic [CNTW-1:0]     count;
    logic                full, push, pop;

    // Lowest channel wins; the extra top bit keeps base+size from wrapping around the address space.
    always_comb begin
        hit     = 1'b0;
        hit_sel = '0;
        lo      = '0;
        hi      = '0;
        for (int i = NUM_EXT - 1; i >= 0; i--) begin
            lo = {1'b0, EXT_BASE[i*ADDRW +: ADDRW]};
            hi = lo + {1'b0, EXT_SIZE[i*ADDRW +: ADDRW]};
            if (EXT_SIZE[i*ADDRW +: ADDRW] != '0 && {1'b0, addr_q} >= lo && {1'b0, addr_q} < hi) begin
                hit     = 1'b1;
                hit_sel = SELW'(i);
            end
        end
    end

    always_comb begin
        rsp_slice  = ext_rsp_data[sel_q*LDW +: LDW];
        rsp_masked = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (tmask_q[l]) rsp_masked[l*DATAW +: DATAW] = rsp_slice[l*DATAW +: DATAW];
        end
    end

    // All handshakes transfer on a cycle where valid && ready; a raised valid and its fields hold until then.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wid_q       <= '0;
            tmask_q     <= '0;
            data_q      <= '0;
            tag_q       <= '0;
            sel_q       <= '0;
            timer       <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            ext_valid_q <= '0;
            drain_q     <= '0;
        end else begin
            case (state)
                S_IDLE: if (req_valid) begin
                    write_q <= req_write;
                    addr_q  <= req_addr;
                    wid_q   <= req_wid;
                    tmask_q <= req_tmask;
                    data_q  <= req_data;
                    tag_q   <= req_tag;
                    drain_q <= req_wid;
                    state   <= S_DRAIN;
                end
                S_DRAIN: if (drain_empty) begin
                    drain_q <= '0;
                    timer   <= '0;
                    if (hit) begin
                        sel_q       <= hit_sel;
                        ext_valid_q <= NUM_EXT'(1) << hit_sel;
                        state       <= S_ISSUE;
                    end else begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                        state   <= S_PUSH;
                    end
                end
                S_ISSUE: if (ext_req_ready[sel_q]) begin
                    ext_valid_q <= '0;
                    timer       <= '0;
                    if (write_q) begin
                        err_q   <= 1'b0;
                        rdata_q <= '0;
                        state   <= S_PUSH;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A response arriving on the timeout cycle still counts as a good response.
                    if (ext_rsp_valid[sel_q]) begin
                        rdata_q <= rsp_masked;
                        err_q   <= 1'b0;
                        state   <= S_PUSH;
                    end else if (timer == TMRW'(TIMEOUT)) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        state   <= S_PUSH;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_PUSH: if (!full) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        return (p == PTRW'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full = (count == CNTW'(OUT_DEPTH));
    assign push = (state == S_PUSH) && !full;
    assign pop  = rsp_valid && rsp_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < OUT_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {tag_q, wid_q, tmask_q, rdata_q, err_q};
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

    assign {rsp_tag, rsp_wid, rsp_tmask, rsp_data, rsp_err} = mem[rd_ptr];
    assign rsp_valid     = (count != '0);
    assign req_ready     = (state == S_IDLE) && !reset;
    assign drain_wid     = drain_q;
    assign ext_req_valid = ext_valid_q;
    assign ext_req_write = write_q;
    assign ext_req_addr  = addr_q;
    assign ext_req_wid   = wid_q;
    assign ext_req_tmask = tmask_q;
    assign ext_req_data  = data_q;
    assign busy          = (state != S_IDLE) || (count != '0);

endmodule

// File: tb/tb_vx_csr_ext_router.sv
// Directed and randomized bench for vx_csr_ext_router: channel 0 at 0x100/0x20, channel 1 at 0x7C0/0x10,
// TIMEOUT 4, two-entry response FIFO.
module tb_vx_csr_ext_router;
    localparam int NL  = 4;
    localparam int NE  = 2;
    localparam int DW  = 32;
    localparam int AW  = 12;
    localparam int WW  = 4;
    localparam int TW  = 8;
    localparam int TO  = 4;
    localparam int OD  = 2;
    localparam int LDW = NL * DW;
    localparam int EW  = TW + WW + NL + LDW + 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid, req_ready, req_write;
    logic [AW-1:0]     req_addr;
    logic [WW-1:0]     req_wid;
    logic [NL-1:0]     req_tmask;
    logic [LDW-1:0]    req_data;
    logic [TW-1:0]     req_tag;
    logic [WW-1:0]     drain_wid;
    logic              drain_empty;
    logic [NE-1:0]     ext_req_valid, ext_req_ready;
    logic              ext_req_write;
    logic [AW-1:0]     ext_req_addr;
    logic [WW-1:0]     ext_req_wid;
    logic [NL-1:0]     ext_req_tmask;
    logic [LDW-1:0]    ext_req_data;
    logic [NE-1:0]     ext_rsp_valid;
    logic [NE*LDW-1:0] ext_rsp_data;
    logic              rsp_valid, rsp_ready;
    logic [TW-1:0]     rsp_tag;
    logic [WW-1:0]     rsp_wid;
    logic [NL-1:0]     rsp_tmask;
    logic [LDW-1:0]    rsp_data;
    logic              rsp_err, busy;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] got_q[$];
    int n_checks = 0;
    int n_errors = 0;

    vx_csr_ext_router #(
        .NUM_LANES(NL), .NUM_EXT(NE), .DATAW(DW), .ADDRW(AW), .WIDW(WW), .TAGW(TW),
        .EXT_BASE({12'h7C0, 12'h100}), .EXT_SIZE({12'h010, 12'h020}),
        .TIMEOUT(TO), .OUT_DEPTH(OD)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_addr(req_addr),
        .req_wid(req_wid), .req_tmask(req_tmask), .req_data(req_data), .req_tag(req_tag),
        .drain_wid(drain_wid), .drain_empty(drain_empty),
        .ext_req_valid(ext_req_valid), .ext_req_ready(ext_req_ready), .ext_req_write(ext_req_write),
        .ext_req_addr(ext_req_addr), .ext_req_wid(ext_req_wid), .ext_req_tmask(ext_req_tmask),
        .ext_req_data(ext_req_data), .ext_rsp_valid(ext_rsp_valid), .ext_rsp_data(ext_rsp_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag), .rsp_wid(rsp_wid),
        .rsp_tmask(rsp_tmask), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // response monitor: every handshake on the response port is recorded
    always @(negedge clk) begin
        if (!reset && rsp_valid && rsp_ready)
            got_q.push_back({rsp_tag, rsp_wid, rsp_tmask, rsp_data, rsp_err});
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LDW-1:0] rand_lanes();
        logic [LDW-1:0] v;
        for (int l = 0; l < NL; l++) v[l*DW +: DW] = $urandom;
        return v;
    endfunction

    // reference decode: lowest channel whose [base, base+size) holds the address
    function automatic int exp_ch(input logic [AW-1:0] a);
        int b[NE];
        int s[NE];
        b = '{'h100, 'h7C0};
        s = '{'h20, 'h10};
        for (int i = 0; i < NE; i++)
            if (s[i] != 0 && int'(a) >= b[i] && int'(a) < b[i] + s[i]) return i;
        return -1;
    endfunction

    // driver: one request end to end; returns one cycle after the response was pushed
    // (or in the first WAIT cycle when abort is set)
    task automatic txn(input logic wr, input logic [AW-1:0] addr, input logic [NL-1:0] tm,
                       input logic [LDW-1:0] wdata, input logic [TW-1:0] tag, input logic [WW-1:0] wid,
                       input int drain_dly, input int rdy_dly, input int rsp_dly,
                       input logic [LDW-1:0] rdat, input bit abort, input bit chk_lat);
        int ch;
        int n;
        int cycles;
        bit accepted;
        bit late;
        logic [LDW-1:0] expd;
        ch = exp_ch(addr);
        late = 1'b0;
        n = 0;
        while (req_ready !== 1'b1 && n < 100) begin
            if (n >= 3) rsp_ready = 1'b1;
            step();
            n++;
        end
        chk("req_ready", 256'(req_ready), 256'(1));
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_tmask = tm;
        req_data = wdata; req_tag = tag; req_wid = wid;
        drain_empty = (drain_dly == 0);
        step();
        req_valid = 1'b0; req_addr = AW'($urandom); req_wid = WW'($urandom);
        req_data = rand_lanes(); req_tag = TW'($urandom); req_tmask = NL'($urandom);
        for (int k = 0; k < drain_dly; k++) begin
            chk("drain_wid", 256'(drain_wid), 256'(wid));
            chk("drain_noext", 256'(ext_req_valid), 256'(0));
            step();
        end
        drain_empty = 1'b1;
        chk("drain_wid", 256'(drain_wid), 256'(wid));
        step();
        chk("post_drain_wid", 256'(drain_wid), 256'(0));
        if (ch < 0) begin
            chk("unmapped_noext", 256'(ext_req_valid), 256'(0));
            exp_q.push_back({tag, wid, tm, {LDW{1'b0}}, 1'b1});
        end else begin
            for (int k = 0; k <= rdy_dly; k++) begin
                ext_req_ready = NE'($urandom);
                ext_req_ready[ch] = (k == rdy_dly);
                chk("ext_valid", 256'(ext_req_valid), 256'(1) << ch);
                chk("ext_write", 256'(ext_req_write), 256'(wr));
                chk("ext_addr", 256'(ext_req_addr), 256'(addr));
                chk("ext_wid", 256'(ext_req_wid), 256'(wid));
                chk("ext_tmask", 256'(ext_req_tmask), 256'(tm));
                chk("ext_data", 256'(ext_req_data), 256'(wdata));
                step();
            end
            ext_req_ready = '0;
            chk("issue_done", 256'(ext_req_valid), 256'(0));
            if (wr) begin
                exp_q.push_back({tag, wid, tm, {LDW{1'b0}}, 1'b0});
            end else if (abort) begin
                return;
            end else begin
                accepted = (rsp_dly <= TO);
                cycles = accepted ? rsp_dly + 1 : TO + 1;
                for (int k = 0; k < cycles; k++) begin
                    ext_rsp_data = {rand_lanes(), rand_lanes()};
                    ext_rsp_valid = NE'($urandom);
                    ext_rsp_valid[ch] = accepted && (k == rsp_dly);
                    if (accepted && k == rsp_dly) ext_rsp_data[ch*LDW +: LDW] = rdat;
                    step();
                end
                ext_rsp_valid = '0;
                expd = '0;
                for (int l = 0; l < NL; l++)
                    if (accepted && tm[l]) expd[l*DW +: DW] = rdat[l*DW +: DW];
                exp_q.push_back({tag, wid, tm, expd, !accepted});
                late = !accepted;
            end
        end
        if (late) begin
            ext_rsp_valid[ch] = 1'b1;
            ext_rsp_data = {rand_lanes(), rand_lanes()};
        end
        if (chk_lat) chk("push_lat", 256'(rsp_valid), 256'(0));
        step();
        if (chk_lat) chk("rsp_lat", 256'(rsp_valid), 256'(1));
        ext_rsp_valid = '0;
    endtask

    // scoreboard: drain outstanding responses and compare in order against the expected queue
    task automatic check_rsps();
        int n;
        logic [EW-1:0] g;
        logic [EW-1:0] e;
        n = 0;
        rsp_ready = 1'b1;
        while (got_q.size() < exp_q.size() && n < 300) begin
            step();
            n++;
        end
        repeat (4) step();
        chk("rsp_count", 256'(got_q.size()), 256'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            chk("rsp_entry", 256'(g), 256'(e));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [LDW-1:0] lanes;
        int cls;
        logic [AW-1:0] a;
        logic [AW-1:0] edges[6];
        edges = '{12'h0FF, 12'h120, 12'h11F, 12'h7BF, 12'h7D0, 12'h7CF};

        reset = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wid = '0; req_tmask = '0;
        req_data = '0; req_tag = '0; drain_empty = 1'b1; ext_req_ready = '0;
        ext_rsp_valid = '0; ext_rsp_data = '0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 256'(req_ready), 256'(0));
        chk("rst_rsp_valid", 256'(rsp_valid), 256'(0));
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_ext_valid", 256'(ext_req_valid), 256'(0));
        chk("rst_drain_wid", 256'(drain_wid), 256'(0));
        chk("rst_rsp_data", 256'(rsp_data), 256'(0));
        reset = 1'b0;
        #1;
        chk("rel_req_ready", 256'(req_ready), 256'(1));
        chk("rel_busy", 256'(busy), 256'(0));

        // read channel 1 with a partial lane mask; lane 2 must read back zero
        lanes = {32'h44, 32'h33, 32'h22, 32'h11};
        txn(1'b0, 12'h7C4, 4'b1011, rand_lanes(), 8'h5A, 4'h2, 0, 0, 3, lanes, 1'b0, 1'b1);
        chk("t1_data", 256'(rsp_data), 256'({32'h44, 32'h0, 32'h22, 32'h11}));
        chk("t1_err", 256'(rsp_err), 256'(0));
        chk("t1_tag", 256'(rsp_tag), 256'(8'h5A));
        // minimum-latency read on channel 0
        txn(1'b0, 12'h100, 4'hF, rand_lanes(), 8'h01, 4'h1, 0, 0, 0, rand_lanes(), 1'b0, 1'b1);
        // write with the slave holding ready low for five cycles
        txn(1'b1, 12'h110, 4'b0110, rand_lanes(), 8'h02, 4'h4, 0, 5, 0, rand_lanes(), 1'b0, 1'b1);
        // unmapped address
        txn(1'b0, 12'hFFF, 4'hF, rand_lanes(), 8'h03, 4'h5, 0, 0, 0, rand_lanes(), 1'b0, 1'b1);
        // silent slave: timeout, then a late response that must be dropped
        txn(1'b0, 12'h11F, 4'hF, rand_lanes(), 8'h04, 4'h6, 0, 0, 99, rand_lanes(), 1'b0, 1'b1);
        // response on the timeout cycle itself
        txn(1'b0, 12'h7CF, 4'b1101, rand_lanes(), 8'h05, 4'h8, 0, 1, TO, rand_lanes(), 1'b0, 1'b1);
        // long drain
        txn(1'b1, 12'h7C0, 4'h1, rand_lanes(), 8'h06, 4'h9, 10, 0, 0, rand_lanes(), 1'b0, 1'b1);
        check_rsps();

        // FIFO back-pressure: two queued, third stalls in PUSH
        rsp_ready = 1'b0;
        txn(1'b0, 12'h104, 4'hF, rand_lanes(), 8'h10, 4'h1, 0, 0, 0, rand_lanes(), 1'b0, 1'b0);
        txn(1'b1, 12'h7C8, 4'h3, rand_lanes(), 8'h11, 4'h2, 0, 0, 0, rand_lanes(), 1'b0, 1'b0);
        txn(1'b0, 12'h200, 4'hF, rand_lanes(), 8'h12, 4'h3, 0, 0, 0, rand_lanes(), 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            chk("full_req_ready", 256'(req_ready), 256'(0));
            chk("full_rsp_valid", 256'(rsp_valid), 256'(1));
            chk("full_busy", 256'(busy), 256'(1));
            step();
        end
        chk("full_no_pop", 256'(got_q.size()), 256'(0));
        check_rsps();

        // reset while waiting for a read, with a response already queued
        rsp_ready = 1'b0;
        txn(1'b0, 12'h108, 4'hF, rand_lanes(), 8'h20, 4'h7, 0, 0, 0, rand_lanes(), 1'b0, 1'b0);
        txn(1'b0, 12'h10C, 4'hF, rand_lanes(), 8'h21, 4'h7, 0, 0, 0, rand_lanes(), 1'b1, 1'b0);
        step();
        reset = 1'b1;
        #1;
        chk("mid_rst_req_ready", 256'(req_ready), 256'(0));
        chk("mid_rst_rsp_valid", 256'(rsp_valid), 256'(0));
        chk("mid_rst_busy", 256'(busy), 256'(0));
        step();
        reset = 1'b0;
        #1;
        exp_q.delete();
        chk("mid_rel_req_ready", 256'(req_ready), 256'(1));
        chk("mid_rel_busy", 256'(busy), 256'(0));
        ext_rsp_valid = 2'b01;
        rsp_ready = 1'b1;
        step();
        step();
        ext_rsp_valid = '0;
        repeat (3) step();
        chk("mid_rst_no_rsp", 256'(got_q.size()), 256'(0));
        chk("mid_rst_idle", 256'(busy), 256'(0));

        // randomized traffic
        for (int t = 0; t < 24; t++) begin
            cls = $urandom_range(0, 3);
            case (cls)
                0: a = 12'h100 + AW'($urandom_range(0, 31));
                1: a = 12'h7C0 + AW'($urandom_range(0, 15));
                2: a = edges[$urandom_range(0, 5)];
                default: a = AW'($urandom);
            endcase
            rsp_ready = 1'($urandom_range(0, 1));
            txn(1'($urandom), a, NL'($urandom), rand_lanes(), TW'($urandom), WW'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, TO + 2),
                rand_lanes(), 1'b0, 1'b0);
        end
        check_rsps();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
